// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-ported integer register file with a busy-bit scoreboard for the
//   pipelined RV32 core. It has NUM_RD combinational read ports and NUM_WR
//   synchronous write ports. Each read port sees a same-cycle writeback
//   through a bypass path. Register 0 is hard-wired to zero.
//
// Ports
//   clk        in   1            rising-edge clock
//   rst_n      in   1            asynchronous active-low reset
//   rd_addr    in   NUM_RD*AW    read addresses, port i = [i*AW +: AW]
//   rd_data    out  NUM_RD*XLEN  read data, port i = [i*XLEN +: XLEN]
//   rd_busy    out  NUM_RD       addressed register has an outstanding producer
//   wr_en      in   NUM_WR       write enable per write port
//   wr_addr    in   NUM_WR*AW    write addresses
//   wr_data    in   NUM_WR*XLEN  write data
//   alloc_en   in   1            issue stage claims a destination register
//   alloc_addr in   AW           destination register being claimed
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*XLEN-1:0]   wr_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr
);

  // Storage and busy bits exist only for registers 1..NREGS-1. Register 0
  // is a constant zero and needs neither.
  logic [XLEN-1:0]  regs   [1:NREGS-1];
  logic [NREGS-1:1] busy;

  // Per-register write decode. The write ports are scanned in ascending
  // order, so when several ports hit the same register the highest index
  // wins. The storage update and the read bypass both use this result, so
  // both follow the same priority. An address with no matching register
  // (0, or >= NREGS) never hits. While reset is asserted, all hits are
  // suppressed, which also disables the bypass.
  logic [NREGS-1:1] wr_hit;
  logic [XLEN-1:0]  wr_val [1:NREGS-1];
  logic [NREGS-1:1] alloc_hit;

  always_comb begin
    wr_hit    = '0;
    alloc_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_val[r] = '0;
    end
    if (rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = wr_data[w*XLEN +: XLEN];
          end
        end
        alloc_hit[r] = alloc_en && (alloc_addr == AW'(r));
      end
    end
  end

  // Storage and scoreboard. When an allocation and a writeback hit the
  // same register in one cycle, the allocation takes priority. The
  // writeback belongs to the older producer, and the new producer is
  // still outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
        if (alloc_hit[r]) begin
          busy[r] <= 1'b1;
        end else if (wr_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports. A writeback in the current cycle forwards its data and
  // also lowers the busy flag on the read side. An allocation in the
  // current cycle is not visible on the read side until the next cycle.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        if (rst_n && (rd_addr[i*AW +: AW] == AW'(r))) begin
          rd_data[i*XLEN +: XLEN] = wr_hit[r] ? wr_val[r] : regs[r];
          rd_busy[i]              = busy[r] && !wr_hit[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp, built with two write ports. The
//   reference model keeps the architectural state as plain arrays. A
//   compare process checks every read port against the model on each
//   falling clock edge. Directed scenarios pin the model with literal
//   values, and a randomized phase follows, including asynchronous resets.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   alloc_en;
  logic [AW-1:0]          alloc_addr;

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  // Reference model: architectural register values and outstanding producers.
  logic [XLEN-1:0]  m_regs [NREGS] = '{default: '0};
  logic [NREGS-1:0] m_busy = '0;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .alloc_en(alloc_en),
    .alloc_addr(alloc_addr)
  );

  always #5 clk = ~clk;

  // Find the writeback visible this cycle for an address. The last port
  // that matches wins.
  function automatic void lookup(input logic [AW-1:0] a, output bit hit,
                                 output logic [XLEN-1:0] v);
    hit = 1'b0;
    v   = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && wr_addr[w*AW +: AW] == a && a != 0) begin
        hit = 1'b1;
        v   = wr_data[w*XLEN +: XLEN];
      end
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    bit hit;
    logic [XLEN-1:0] v;
    if (!rst_n || a == 0) return '0;
    lookup(a, hit, v);
    return hit ? v : m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    bit hit;
    logic [XLEN-1:0] v;
    if (!rst_n || a == 0) return 1'b0;
    lookup(a, hit, v);
    return m_busy[a] && !hit;
  endfunction

  // Model state update at the clock edge. Reset clears the model
  // asynchronously, just as it clears the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_busy = '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        bit hit;
        logic [XLEN-1:0] v;
        lookup(AW'(r), hit, v);
        if (hit) m_regs[r] = v;
        if (alloc_en && alloc_addr == AW'(r)) m_busy[r] = 1'b1;
        else if (hit)                         m_busy[r] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                             input logic [XLEN-1:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare every read port against the model on each falling edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      for (int i = 0; i < NUM_RD; i++) begin
        checkOutput($sformatf("model_rd%0d_data", i), rd_data[i*XLEN +: XLEN],
                    exp_data(rd_addr[i*AW +: AW]));
        checkOutput($sformatf("model_rd%0d_busy", i), XLEN'(rd_busy[i]),
                    XLEN'(exp_busy(rd_addr[i*AW +: AW])));
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] we,
                               input logic [AW-1:0] wa0, input logic [XLEN-1:0] wd0,
                               input logic [AW-1:0] wa1, input logic [XLEN-1:0] wd1,
                               input logic ae, input logic [AW-1:0] aa,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en      = we;
    wr_addr    = {wa1, wa0};
    wr_data    = {wd1, wd0};
    alloc_en   = ae;
    alloc_addr = aa;
    rd_addr    = {ra1, ra0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    run_cmp = 1'b1;

    // Reset state.
    settle();
    checkOutput("reset_data", rd_data[31:0], 32'h0);
    checkOutput("reset_busy", XLEN'(rd_busy), 32'h0);
    tick();
    rst_n = 1'b1;

    // Write x5. Then assert reset mid-cycle while another write is pending.
    tick();
    applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    settle();
    checkOutput("x5_bypass", rd_data[31:0], 32'hDEAD_BEEF);
    tick();
    applyStimulus(2'b01, 5'd5, 32'h1111_1111, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async_data", rd_data[31:0], 32'h0);
    checkOutput("reset_async_busy", XLEN'(rd_busy), 32'h0);
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
    settle();
    checkOutput("reset_x5_cleared", rd_data[31:0], 32'h0);

    // x0 ignores writes and allocations.
    tick();
    applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("x0_data", rd_data[31:0], 32'h0);
    checkOutput("x0_busy", XLEN'(rd_busy), 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    settle();
    checkOutput("x0_data_later", rd_data[63:32], 32'h0);
    checkOutput("x0_busy_later", XLEN'(rd_busy), 32'h0);

    // Bypass, then read back from storage.
    tick();
    applyStimulus(2'b01, 5'd7, 32'h1234_5678, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    settle();
    checkOutput("x7_bypass", rd_data[31:0], 32'h1234_5678);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    settle();
    checkOutput("x7_stored", rd_data[31:0], 32'h1234_5678);

    // Write collision: the higher-index port wins.
    tick();
    applyStimulus(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 1'b0, 5'd0, 5'd9, 5'd9);
    settle();
    checkOutput("x9_collide_bypass0", rd_data[31:0], 32'h2);
    checkOutput("x9_collide_bypass1", rd_data[63:32], 32'h2);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
    settle();
    checkOutput("x9_collide_stored", rd_data[31:0], 32'h2);

    // Scoreboard: allocate x3 in cycle N, write it back in N+4.
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0);
    settle();
    checkOutput("sb_busy_N", XLEN'(rd_busy[0]), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0);
      settle();
      checkOutput($sformatf("sb_busy_N%0d", k), XLEN'(rd_busy[0]), 32'h1);
    end
    tick();
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd3, 32'hABCD_0003, 1'b0, 5'd0, 5'd3, 5'd0);
    settle();
    checkOutput("sb_wb_busy", XLEN'(rd_busy[0]), 32'h0);
    checkOutput("sb_wb_data", rd_data[31:0], 32'hABCD_0003);
    tick();
    applyStimulus(2'b01, 5'd3, 32'h55, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd3);
    settle();
    checkOutput("sb_both_busy_now", XLEN'(rd_busy[1]), 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd3);
    settle();
    checkOutput("sb_both_busy_next", XLEN'(rd_busy[0]), 32'h1);
    checkOutput("sb_both_data_next", rd_data[63:32], 32'h55);

    // Randomized traffic with occasional mid-cycle asynchronous resets.
    for (int c = 0; c < 10000; c++) begin
      logic [AW-1:0] a [6];
      tick();
      if (!rst_n && $urandom_range(0, 2) == 0)      rst_n = 1'b1;
      else if (rst_n && $urandom_range(0, 299) == 0) rst_n = 1'b0;
      for (int k = 0; k < 6; k++) begin
        a[k] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS - 1))
                                           : AW'($urandom_range(0, 7));
      end
      applyStimulus(2'($urandom_range(0, 3)), a[0], $urandom, a[1], $urandom,
                    1'($urandom_range(0, 2) == 0), a[2], a[3], a[4]);
    end

    settle();
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
